// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// the canonical NOP, and hold/flush control levels.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PCTRL_RUN   = 2'd0,
    PCTRL_FLUSH = 2'd1,
    PCTRL_BUSY  = 2'd2,
    PCTRL_HALT  = 2'd3
  } pctrl_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic HOLD_ENABLE   = 1'b1;
  localparam logic HOLD_DISABLE  = 1'b0;
  localparam logic FLUSH_ENABLE  = 1'b1;
  localparam logic FLUSH_DISABLE = 1'b0;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: resolves jump,
// multicycle-busy, load-use and debug-halt into hold/flush/redirect controls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int JUMP_FLUSH_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_reg1_r_addr_i,
  input  logic [4:0]       id_reg2_r_addr_i,
  input  logic [4:0]       ex_reg_w_addr_i,
  input  logic             ex_mem_r_ena_i,
  input  logic             ex_jump_ena_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             ex_busy_i,
  input  logic             halt_req_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             jump_ena_o,
  output logic [31:0]      jump_addr_o,
  output logic             halt_ack_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0]   JFC       = 2'(JUMP_FLUSH_CYCLES);
  localparam pctrl_state_t JUMP_NEXT = (JUMP_FLUSH_CYCLES == 0) ? PCTRL_RUN : PCTRL_FLUSH;

  pctrl_state_t state, state_nxt;
  logic [1:0]   fcnt, fcnt_nxt;
  logic         lu;

  // rd==0 never matches: x0 is never actually written by a load
  assign lu = ex_mem_r_ena_i && (ex_reg_w_addr_i != 5'd0) &&
              ((ex_reg_w_addr_i == id_reg1_r_addr_i) || (ex_reg_w_addr_i == id_reg2_r_addr_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PCTRL_RUN;
      fcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fcnt_nxt      = fcnt;
    hold_pc_o     = HOLD_DISABLE;
    hold_if_id_o  = HOLD_DISABLE;
    flush_if_id_o = FLUSH_DISABLE;
    flush_id_ex_o = FLUSH_DISABLE;
    jump_ena_o    = 1'b0;
    jump_addr_o   = 32'd0;
    halt_ack_o    = 1'b0;
    if (!rst) begin
      if (state == PCTRL_HALT) begin
        hold_pc_o     = HOLD_ENABLE;
        hold_if_id_o  = HOLD_ENABLE;
        flush_id_ex_o = FLUSH_ENABLE;
        halt_ack_o    = 1'b1;
        if (!halt_req_i) state_nxt = PCTRL_RUN;
      end else if (ex_jump_ena_i) begin
        jump_ena_o    = 1'b1;
        jump_addr_o   = ex_jump_addr_i;
        flush_if_id_o = FLUSH_ENABLE;
        flush_id_ex_o = FLUSH_ENABLE;
        state_nxt     = JUMP_NEXT;
        fcnt_nxt      = JFC;
      end else if (state == PCTRL_FLUSH) begin
        // decode only ever sees a NOP here, so load-use cannot arise
        flush_if_id_o = FLUSH_ENABLE;
        if (ex_busy_i) begin
          hold_pc_o = HOLD_ENABLE;
        end else if (fcnt <= 2'd1) begin
          state_nxt = PCTRL_RUN;
          fcnt_nxt  = 2'd0;
        end else begin
          fcnt_nxt = fcnt - 2'd1;
        end
      end else if (ex_busy_i) begin
        hold_pc_o    = HOLD_ENABLE;
        hold_if_id_o = HOLD_ENABLE;
        state_nxt    = PCTRL_BUSY;
      end else if (lu) begin
        hold_pc_o     = HOLD_ENABLE;
        hold_if_id_o  = HOLD_ENABLE;
        flush_id_ex_o = FLUSH_ENABLE;
        state_nxt     = PCTRL_RUN;
      end else if ((state == PCTRL_RUN) && halt_req_i) begin
        state_nxt = PCTRL_HALT;
      end else begin
        state_nxt = PCTRL_RUN;
      end
    end
  end

  assign state_o = state;

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hold_pc_o),
    .value (stall_cnt_o)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (jump_ena_o),
    .value (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, jumps, busy, halt, saturation and
// asynchronous reset, with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id1, id2, exw;
  logic          memr, jmp, busy, hreq;
  logic [31:0]   jaddr;
  logic          hold_pc, hold_if_id, flush_if_id, flush_id_ex, jump_ena, halt_ack;
  logic [31:0]   jump_addr;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.JUMP_FLUSH_CYCLES(1), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_reg1_r_addr_i (id1),
    .id_reg2_r_addr_i (id2),
    .ex_reg_w_addr_i  (exw),
    .ex_mem_r_ena_i   (memr),
    .ex_jump_ena_i    (jmp),
    .ex_jump_addr_i   (jaddr),
    .ex_busy_i        (busy),
    .halt_req_i       (hreq),
    .hold_pc_o        (hold_pc),
    .hold_if_id_o     (hold_if_id),
    .flush_if_id_o    (flush_if_id),
    .flush_id_ex_o    (flush_id_ex),
    .jump_ena_o       (jump_ena),
    .jump_addr_o      (jump_addr),
    .halt_ack_o       (halt_ack),
    .state_o          (state),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // hold_pc, hold_if_id, flush_if_id, flush_id_ex packed MSB first
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, hold_pc, hold_if_id, flush_if_id, flush_id_ex}, {28'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id1 = 0; id2 = 0; exw = 0; memr = 0; jmp = 0; busy = 0; hreq = 0; jaddr = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    jmp = 1; jaddr = 32'h40; busy = 1;
    #1;
    chk("rst_jump_gated", {31'd0, jump_ena}, 32'd0);
    chk("rst_addr_gated", jump_addr, 32'd0);
    chk_ctl("rst_ctl_gated", 4'b0000);
    clear_in();
    rst = 1'b0;
    step();

    // load-use via rs1
    memr = 1; exw = 5; id1 = 5;
    #1;
    chk_ctl("lu_rs1_ctl", 4'b1101);
    chk("lu_rs1_stall_before", 32'(stall_cnt), 32'd0);
    step();
    chk("lu_rs1_stall_after", 32'(stall_cnt), 32'd1);
    memr = 0;
    #1;
    chk_ctl("lu_cleared", 4'b0000);
    chk("lu_state", 32'(state), 32'd0);

    // rd=0 must not match rs=0
    memr = 1; exw = 0; id1 = 0; id2 = 0;
    #1;
    chk_ctl("lu_x0", 4'b0000);
    // load-use via rs2
    exw = 7; id1 = 3; id2 = 7;
    #1;
    chk_ctl("lu_rs2_ctl", 4'b1101);
    step();
    chk("lu_rs2_stall", 32'(stall_cnt), 32'd2);
    clear_in();

    // taken jump, one extra flush cycle
    jmp = 1; jaddr = 32'h0000_0040;
    #1;
    chk("jmp_ena", {31'd0, jump_ena}, 32'd1);
    chk("jmp_addr", jump_addr, 32'h40);
    chk_ctl("jmp_ctl", 4'b0011);
    step();
    jmp = 0;
    #1;
    chk("flush_state", 32'(state), 32'd1);
    chk_ctl("flush_ctl", 4'b0010);
    chk("flush_addr_zero", jump_addr, 32'd0);
    chk("flush_cnt1", 32'(flush_cnt), 32'd1);
    step();
    chk("post_flush_state", 32'(state), 32'd0);
    chk_ctl("post_flush_ctl", 4'b0000);

    // jump beats simultaneous load-use
    jmp = 1; jaddr = 32'h80; memr = 1; exw = 5; id1 = 5;
    #1;
    chk_ctl("jmp_lu_ctl", 4'b0011);
    chk("jmp_lu_addr", jump_addr, 32'h80);
    step();
    jmp = 0;
    #1;
    chk("jmp_lu_stall", 32'(stall_cnt), 32'd2);
    chk("jmp_lu_flushcnt", 32'(flush_cnt), 32'd2);
    chk_ctl("flush_ignores_lu", 4'b0010);
    clear_in();
    step();
    chk("jmp_lu_back_run", 32'(state), 32'd0);

    // busy for 4 cycles
    for (int i = 0; i < 4; i++) begin
      busy = 1;
      #1;
      chk_ctl("busy_ctl", 4'b1100);
      chk("busy_state", 32'(state), (i == 0) ? 32'd0 : 32'd2);
      step();
    end
    busy = 0;
    #1;
    chk("busy_drop_state", 32'(state), 32'd2);
    chk_ctl("busy_drop_ctl", 4'b0000);
    step();
    chk("busy_run", 32'(state), 32'd0);
    chk("busy_stall", 32'(stall_cnt), 32'd6);

    // busy during FLUSH: counter frozen, flush wins at if_id
    jmp = 1; jaddr = 32'h100;
    step();
    jmp = 0; busy = 1;
    #1;
    chk_ctl("flush_busy_ctl", 4'b1010);
    step();
    chk("flush_busy_state", 32'(state), 32'd1);
    chk("flush_busy_stall", 32'(stall_cnt), 32'd7);
    busy = 0;
    #1;
    chk_ctl("flush_resume_ctl", 4'b0010);
    step();
    chk("flush_busy_run", 32'(state), 32'd0);
    chk("flush_busy_fcnt", 32'(flush_cnt), 32'd3);

    // halt request 3 cycles
    hreq = 1;
    #1;
    chk("halt_c1_ack", {31'd0, halt_ack}, 32'd0);
    chk_ctl("halt_c1_ctl", 4'b0000);
    step();
    jmp = 1; jaddr = 32'h200; busy = 1;
    #1;
    chk("halt_c2_state", 32'(state), 32'd3);
    chk("halt_c2_ack", {31'd0, halt_ack}, 32'd1);
    chk_ctl("halt_c2_ctl", 4'b1101);
    chk("halt_jump_ignored", {31'd0, jump_ena}, 32'd0);
    step();
    jmp = 0; busy = 0;
    #1;
    chk("halt_c3_ack", {31'd0, halt_ack}, 32'd1);
    step();
    hreq = 0;
    #1;
    chk("halt_drop_ack", {31'd0, halt_ack}, 32'd1);
    step();
    chk("halt_exit_state", 32'(state), 32'd0);
    chk("halt_exit_ack", {31'd0, halt_ack}, 32'd0);
    chk("halt_stall", 32'(stall_cnt), 32'd10);

    // stall counter saturates at all-ones
    busy = 1;
    for (int i = 0; i < 8; i++) step();
    busy = 0;
    step();
    chk("stall_sat", 32'(stall_cnt), 32'd15);

    // async reset in the middle of FLUSH
    jmp = 1; jaddr = 32'h300;
    step();
    jmp = 0;
    #1;
    chk("pre_rst_state", 32'(state), 32'd1);
    chk("pre_rst_fcnt", 32'(flush_cnt), 32'd4);
    #1;
    rst = 1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_stall", 32'(stall_cnt), 32'd0);
    chk("async_rst_flush", 32'(flush_cnt), 32'd0);
    chk_ctl("async_rst_ctl", 4'b0000);
    rst = 0;
    step();
    chk("post_rst_state", 32'(state), 32'd0);
    chk_ctl("post_rst_ctl", 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Watches the decode stage's register read addresses, the id_ex latch contents, and EX jump/busy/halt requests.
- Drives hold (stall) and flush controls to the pc, if_id and id_ex registers, and forwards the redirect to pc.
- Provides stall and flush performance counters.

Parameters:
- JUMP_FLUSH_CYCLES, 1, extra cycles if_id stays flushed after a taken jump, covering in-flight fetch from synchronous ROM; legal range 0..3.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- id_reg1_r_addr_i  in  5  rs1 read address from decode; 0 means unused
- id_reg2_r_addr_i  in  5  rs2 read address from decode; 0 means unused
- ex_reg_w_addr_i  in  5  rd of the instruction now in EX (id_ex output)
- ex_mem_r_ena_i  in  1  instruction in EX is a load
- ex_jump_ena_i  in  1  EX resolved a taken branch/jump this cycle
- ex_jump_addr_i  in  32  redirect target
- ex_busy_i  in  1  EX multicycle op in progress
- halt_req_i  in  1  debug halt request, level
- hold_pc_o  out  1  pc keeps its value
- hold_if_id_o  out  1  if_id keeps its contents
- flush_if_id_o  out  1  if_id loads NOP (0x00000013)
- flush_id_ex_o  out  1  id_ex loads bubble: all enables 0, addresses 0
- jump_ena_o  out  1  pc redirect enable
- jump_addr_o  out  32  pc redirect target
- halt_ack_o  out  1  core is halted
- state_o  out  2  current FSM state, for debug
- stall_cnt_o  out  CNT_W  cycles with hold_pc_o=1
- flush_cnt_o  out  CNT_W  taken jumps

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values: state RUN, flush counter 0, both perf counters 0. All outputs 0 while rst is high, except state_o=RUN.
- Control outputs are combinational from inputs plus registered state. Counters are registered and update on the clk rising edge.
- FSM states, encoded in the shared package: RUN=0, FLUSH=1, BUSY=2, HALT=3.
- Load-use hazard: lu = ex_mem_r_ena_i & (ex_reg_w_addr_i != 0) & (ex_reg_w_addr_i == id_reg1_r_addr_i | ex_reg_w_addr_i == id_reg2_r_addr_i).
  - Source addresses equal to 0 never match.
- Priority each cycle: jump > busy > load-use > halt.
- Jump (any state except HALT):
  - jump_ena_o=1, jump_addr_o=ex_jump_addr_i.
  - flush_if_id_o=1, flush_id_ex_o=1, no holds.
  - Next state: FLUSH with counter=JUMP_FLUSH_CYCLES, or RUN if that is 0.
  - flush_cnt_o increments.
  - jump_addr_o is 0 whenever jump_ena_o is 0.
- FLUSH:
  - flush_if_id_o=1 each cycle; counter decrements; return to RUN when counter reaches 1 at a clock edge.
  - Load-use is ignored: decode holds a NOP.
  - A new jump during FLUSH reloads the counter.
  - ex_busy_i during FLUSH: hold_pc_o=1 and flush_if_id_o=1, counter frozen.
- Busy (RUN only, ex_busy_i=1):
  - hold_pc_o=1, hold_if_id_o=1, id_ex held by external EX gating; flush_id_ex_o=0.
  - Next state BUSY; stay while ex_busy_i=1; return to RUN the cycle after it drops.
- Load-use in RUN:
  - hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1 for exactly one cycle.
  - No state change; the bubble removes the load from EX, so the hazard self-clears.
- Halt: in RUN with no jump, busy or load-use and halt_req_i=1, go to HALT.
  - HALT holds pc and if_id, flushes id_ex, halt_ack_o=1.
  - Return to RUN the cycle after halt_req_i=0.
  - jump and busy inputs are ignored in HALT.
- hold_* and flush_if_id_o are never both asserted for the same register except in FLUSH+busy, where flush wins at if_id.
- stall_cnt_o increments every cycle hold_pc_o=1.
- Both counters saturate at all-ones and do not wrap.
- Reset asserted mid-FLUSH/BUSY/HALT: immediate return to RUN; pending flush count is discarded.

Decomposition:
- define.v gains:
  - state encodings PCTRL_RUN/FLUSH/BUSY/HALT;
  - NOP_INST 32'h00000013;
  - HOLD_ENABLE/HOLD_DISABLE and FLUSH_ENABLE/FLUSH_DISABLE constants.
- One sub-module, sat_cnt (parameter W; ports clk, rst, inc; output value), instantiated twice.

Test Plan:
- Load x5 in EX, ID reads rs1=5 -> exactly one cycle of hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1; stall_cnt_o 0->1.
- Load with rd=0 in EX, ID reads rs1=0 -> no hold, no flush.
- ex_jump_ena_i=1, addr 0x0000_0040, JUMP_FLUSH_CYCLES=1 -> cycle0: jump_ena_o=1, jump_addr_o=0x40, both flushes; cycle1: flush_if_id_o only; cycle2: RUN, flush_cnt_o=1.
- Jump and load-use hazard in same cycle -> jump behaviour only, no hold, stall_cnt_o unchanged.
- ex_busy_i high for 4 cycles -> hold_pc_o high 4 cycles, state_o=2, RUN on cycle 5, stall_cnt_o=4.
- halt_req_i high 3 cycles then low, then rst pulsed during a FLUSH -> halt_ack_o high 3 cycles; on reset, state_o=0 and counters 0 asynchronously.
